// File: rtl/muldiv_unit_with_lock.sv
// Shared iterative MULT/MULTU/DIV/DIVU unit behind the SIC req/grant/release lock.
// Define MDU_FAST_MUL_EN for single-cycle multiplies; divides always iterate.
module muldiv_unit_with_lock #(
  parameter int NUM_PORTS = 2,
  parameter int ID_WIDTH  = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_PORTS-1:0]          sic_req,
  input  logic [NUM_PORTS*ID_WIDTH-1:0] sic_issue_id,
  input  logic [NUM_PORTS-1:0]          sic_release,
  input  logic [NUM_PORTS*32-1:0]       sic_op_a,
  input  logic [NUM_PORTS*32-1:0]       sic_op_b,
  input  logic [NUM_PORTS*2-1:0]        sic_op_code,
  output logic [NUM_PORTS-1:0]          sic_grant_out,
  output logic [NUM_PORTS-1:0]          sic_done_out,
  output logic [NUM_PORTS*32-1:0]       sic_hi_out,
  output logic [NUM_PORTS*32-1:0]       sic_lo_out
);

  localparam int OW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [OW-1:0] owner_q, owner_d;
  logic [31:0]   a_q, a_d;
  logic [31:0]   b_q, b_d;
  logic [1:0]    op_q, op_d;
  logic [31:0]   hi_q, hi_d;
  logic [31:0]   lo_q, lo_d;
  logic [4:0]    cnt_q, cnt_d;

  function automatic logic [31:0] mag(input logic [31:0] x,
                                      input logic s);
    return (s & x[31]) ? -x : x;
  endfunction

  // Oldest-ID arbitration; ties keep the lower index.
  logic                win_vld;
  logic [OW-1:0]       win_idx;
  logic [ID_WIDTH-1:0] win_id;
  logic [ID_WIDTH-1:0] cur_id;
  logic [ID_WIDTH-1:0] id_diff;

  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    win_id  = '0;
    cur_id  = '0;
    id_diff = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      cur_id  = sic_issue_id[i*ID_WIDTH +: ID_WIDTH];
      id_diff = cur_id - win_id;
      if (sic_req[i] && (!win_vld || id_diff[ID_WIDTH-1])) begin
        win_vld = 1'b1;
        win_idx = OW'(i);
        win_id  = cur_id;
      end
    end
  end

  logic [1:0]  new_op;
  logic [31:0] new_a;
  logic [31:0] new_b;

  always_comb begin
    new_op = sic_op_code[win_idx*2 +: 2];
    new_a  = sic_op_a[win_idx*32 +: 32];
    new_b  = sic_op_b[win_idx*32 +: 32];
  end

  logic        sgn;
  logic        a_neg;
  logic        res_neg;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [32:0] mul_sum;
  logic [32:0] div_r;
  logic [33:0] div_diff;
  logic        div_ge;
  logic [31:0] it_hi;
  logic [31:0] it_lo;
  logic [63:0] mul_res;
  logic [63:0] div_res;

  always_comb begin
    sgn      = ~op_q[0];
    a_neg    = sgn & a_q[31];
    res_neg  = a_neg ^ (sgn & b_q[31]);
    a_mag    = mag(a_q, sgn);
    b_mag    = mag(b_q, sgn);
    mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, a_mag} : 33'd0);
    div_r    = {hi_q, lo_q[31]};
    div_diff = {1'b0, div_r} - {2'b00, b_mag};
    div_ge   = ~div_diff[33];
    if (op_q[1]) begin
      it_hi = div_ge ? div_diff[31:0] : div_r[31:0];
      it_lo = {lo_q[30:0], div_ge};
    end else begin
      it_hi = mul_sum[32:1];
      it_lo = {mul_sum[0], lo_q[31:1]};
    end
    mul_res = res_neg ? -{it_hi, it_lo} : {it_hi, it_lo};
    if (b_q == 32'd0)
      div_res = {a_q, 32'hFFFF_FFFF};
    else
      div_res = {a_neg ? -it_hi : it_hi,
                 res_neg ? -it_lo : it_lo};
  end

`ifdef MDU_FAST_MUL_EN
  logic [63:0] fast_sa;
  logic [63:0] fast_sb;
  logic [63:0] fast_prod;

  always_comb begin
    fast_sa   = {{32{a_q[31] & sgn}}, a_q};
    fast_sb   = {{32{b_q[31] & sgn}}, b_q};
    fast_prod = fast_sa * fast_sb;
  end
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d = BUSY;
          owner_d = win_idx;
          a_d     = new_a;
          b_d     = new_b;
          op_d    = new_op;
          cnt_d   = 5'd0;
          hi_d    = 32'd0;
          lo_d    = new_op[1] ? mag(new_a, ~new_op[0])
                              : mag(new_b, ~new_op[0]);
        end
      end
      BUSY: begin
        if (sic_release[owner_q]) begin
          state_d = IDLE;
`ifdef MDU_FAST_MUL_EN
        end else if (!op_q[1]) begin
          state_d = DONE;
          {hi_d, lo_d} = fast_prod;
`endif
        end else begin
          cnt_d = cnt_q + 5'd1;
          hi_d  = it_hi;
          lo_d  = it_lo;
          if (cnt_q == 5'd31) begin
            state_d = DONE;
            {hi_d, lo_d} = op_q[1] ? div_res : mul_res;
          end
        end
      end
      DONE: begin
        if (sic_release[owner_q])
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      sic_grant_out[i] = (state_q != IDLE) && (owner_q == OW'(i));
      sic_done_out[i]  = (state_q == DONE) && (owner_q == OW'(i));
      sic_hi_out[i*32 +: 32] = sic_done_out[i] ? hi_q : 32'd0;
      sic_lo_out[i*32 +: 32] = sic_done_out[i] ? lo_q : 32'd0;
    end
  end

endmodule

// File: tb/tb_muldiv_unit_with_lock.sv
// Directed bench for muldiv_unit_with_lock: arithmetic, arbitration,
// abort by release, and async reset.
module tb_muldiv_unit_with_lock;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sic_req;
  logic [31:0] sic_issue_id;
  logic [1:0]  sic_release;
  logic [63:0] sic_op_a;
  logic [63:0] sic_op_b;
  logic [3:0]  sic_op_code;
  logic [1:0]  sic_grant_out;
  logic [1:0]  sic_done_out;
  logic [63:0] sic_hi_out;
  logic [63:0] sic_lo_out;

  int n_tests = 0;
  int n_fail  = 0;

  localparam logic [1:0] MULT  = 2'b00;
  localparam logic [1:0] MULTU = 2'b01;
  localparam logic [1:0] DIV   = 2'b10;
  localparam logic [1:0] DIVU  = 2'b11;

  muldiv_unit_with_lock #(.NUM_PORTS(2), .ID_WIDTH(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .sic_req      (sic_req),
    .sic_issue_id (sic_issue_id),
    .sic_release  (sic_release),
    .sic_op_a     (sic_op_a),
    .sic_op_b     (sic_op_b),
    .sic_op_code  (sic_op_code),
    .sic_grant_out(sic_grant_out),
    .sic_done_out (sic_done_out),
    .sic_hi_out   (sic_hi_out),
    .sic_lo_out   (sic_lo_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup(input int p, input logic [15:0] id,
                       input logic [1:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    sic_req[p]             = 1'b1;
    sic_issue_id[p*16+:16] = id;
    sic_op_code[p*2+:2]    = op;
    sic_op_a[p*32+:32]     = a;
    sic_op_b[p*32+:32]     = b;
  endtask

  function automatic int exp_lat(input logic [1:0] op);
`ifdef MDU_FAST_MUL_EN
    if (!op[1]) return 1;
`endif
    return 32;
  endfunction

  // Full transaction on port p: grant, latency, result, release.
  task automatic run_op(input string tag, input int p,
                        input logic [15:0] id, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el);
    logic [1:0] g;
    int lat;
    g = 2'b01 << p;
    setup(p, id, op, a, b);
    step();
    check({tag, "_grant"}, sic_grant_out, g);
    sic_req[p]          = 1'b0;
    sic_op_a[p*32+:32]  = 32'hDEAD_BEEF;
    sic_op_b[p*32+:32]  = 32'h0BAD_F00D;
    sic_op_code[p*2+:2] = ~op;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (sic_done_out[p]) begin
        lat = k;
        break;
      end
    end
    check({tag, "_lat"}, lat, exp_lat(op));
    check({tag, "_res"},
          {sic_hi_out[p*32+:32], sic_lo_out[p*32+:32]}, {eh, el});
    check({tag, "_other"}, {sic_grant_out, sic_done_out}, {g, g});
    sic_release[p] = 1'b1;
    step();
    sic_release[p] = 1'b0;
    check({tag, "_rel"},
          {sic_grant_out, sic_done_out, sic_hi_out, sic_lo_out}, '0);
  endtask

  task automatic arb(input string tag,
                     input logic [15:0] id0, input logic [15:0] id1,
                     input logic [1:0] eg);
    setup(0, id0, DIVU, 32'd9, 32'd3);
    setup(1, id1, DIVU, 32'd8, 32'd2);
    step();
    check(tag, sic_grant_out, eg);
    sic_req     = 2'b00;
    sic_release = 2'b11;
    step();
    sic_release = 2'b00;
    check({tag, "_rel"}, sic_grant_out, 2'b00);
  endtask

  initial begin
    logic d0_seen;
    int lat;
    rst_n        = 1'b0;
    sic_req      = '0;
    sic_issue_id = '0;
    sic_release  = '0;
    sic_op_a     = '0;
    sic_op_b     = '0;
    sic_op_code  = '0;
    step();
    step();
    check("reset_out",
          {sic_grant_out, sic_done_out, sic_hi_out, sic_lo_out}, '0);
    rst_n = 1'b1;
    step();

    // T1..T3 arithmetic
    run_op("multu_ff", 0, 16'd1, MULTU, 32'hFFFF_FFFF, 32'd2,
           32'd1, 32'hFFFF_FFFE);
    run_op("mult_neg", 1, 16'd2, MULT, 32'hFFFF_FFFD, 32'd5,
           32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_op("multu_sh", 0, 16'd3, MULTU, 32'h1234_5678, 32'h10,
           32'd1, 32'h2345_6780);
    run_op("div_neg", 0, 16'd4, DIV, 32'hFFFF_FFF9, 32'd2,
           32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_negb", 1, 16'd5, DIV, 32'd7, 32'hFFFF_FFFE,
           32'd1, 32'hFFFF_FFFD);
    run_op("divu_0", 0, 16'd6, DIVU, 32'd7, 32'd0,
           32'd7, 32'hFFFF_FFFF);
    run_op("div_0", 1, 16'd7, DIV, 32'hFFFF_FFFB, 32'd0,
           32'hFFFF_FFFB, 32'hFFFF_FFFF);
    run_op("div_ovf", 0, 16'd8, DIV, 32'h8000_0000, 32'hFFFF_FFFF,
           32'd0, 32'h8000_0000);
    run_op("divu_100", 1, 16'd9, DIVU, 32'd100, 32'd7,
           32'd2, 32'd14);

    // T4 arbitration
    arb("arb_older1", 16'd5, 16'd3, 2'b10);
    arb("arb_wrap", 16'hFFFE, 16'h0001, 2'b01);
    arb("arb_equal", 16'd42, 16'd42, 2'b01);

    // T5 abort at iteration 10 while port1 waits
    setup(0, 16'd10, MULTU, 32'd3, 32'd4);
    setup(1, 16'd20, DIVU, 32'd100, 32'd7);
    step();
    check("t5_grant0", sic_grant_out, 2'b01);
    sic_req[0] = 1'b0;
    d0_seen = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      step();
      if (sic_done_out[0]) d0_seen = 1'b1;
    end
    sic_release[0] = 1'b1;
    step();
    sic_release[0] = 1'b0;
    if (sic_done_out[0]) d0_seen = 1'b1;
    check("t5_bubble", {sic_grant_out, sic_done_out}, 4'b0000);
    check("t5_nodone", d0_seen, 1'b0);
    step();
    check("t5_grant1", sic_grant_out, 2'b10);
    sic_req[1]     = 1'b0;
    sic_release[0] = 1'b1;
    step();
    sic_release[0] = 1'b0;
    check("t5_nonowner_rel", sic_grant_out, 2'b10);
    lat = 0;
    for (int k = 2; k <= 40; k++) begin
      step();
      if (sic_done_out[1]) begin
        lat = k;
        break;
      end
    end
    check("t5_lat1", lat, 32);
    check("t5_res1", {sic_hi_out[63:32], sic_lo_out[63:32]},
          {32'd2, 32'd14});
    sic_release[1] = 1'b1;
    step();
    sic_release[1] = 1'b0;

    // T6 async reset mid-BUSY and in DONE
    setup(0, 16'd30, MULTU, 32'd6, 32'd7);
    step();
    sic_req[0] = 1'b0;
    for (int k = 0; k < 5; k++) step();
    check("t6_busy_grant", sic_grant_out, 2'b01);
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",
          {sic_grant_out, sic_done_out, sic_hi_out, sic_lo_out}, '0);
    step();
    rst_n = 1'b1;
    setup(1, 16'd31, DIVU, 32'd100, 32'd7);
    step();
    sic_req[1] = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (sic_done_out[1]) begin
        lat = k;
        break;
      end
    end
    check("t6_done_lat", lat, 32);
    rst_n = 1'b0;
    #1;
    check("t6_rst_done",
          {sic_grant_out, sic_done_out, sic_hi_out, sic_lo_out}, '0);
    step();
    rst_n = 1'b1;
    step();
    run_op("t6_after", 0, 16'd32, MULT, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
           32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
